// File: rtl/sata_pkg.sv
// Shared constants, FSM state type and lane-priority helper for the SATA
// receive dword aligner.
package sata_pkg;

    localparam logic [31:0] SATA_ALIGN_DATA = 32'h7B4A4ABC;
    localparam logic [3:0]  SATA_ALIGN_K    = 4'b0001;

    // Bytes of the {current, previous} window that can ever hold a candidate:
    // lane 3 reaches only byte 2 of the current word.
    localparam int unsigned WIN_BYTES = 7;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } aligner_state_t;

    // Lowest matching lane wins when several lanes match at once.
    function automatic logic [1:0] lowest_lane(input logic [3:0] match);
        logic [1:0] lane;
        if (match[0]) begin
            lane = 2'd0;
        end else if (match[1]) begin
            lane = 2'd1;
        end else if (match[2]) begin
            lane = 2'd2;
        end else begin
            lane = 2'd3;
        end
        return lane;
    endfunction

endpackage

// File: rtl/sata_dword_lane_matcher.sv
// Compares each of the four byte-offset candidates in the receive window
// against the ALIGN primitive (data and K-flags).
module sata_dword_lane_matcher
    import sata_pkg::*;
(
    input  logic [8*WIN_BYTES-1:0] win_data_i,
    input  logic [WIN_BYTES-1:0]   win_datak_i,
    output logic [3:0]             match_o
);

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign match_o[k] = (win_data_i[8*k +: 32] == SATA_ALIGN_DATA) &&
                            (win_datak_i[k +: 4] == SATA_ALIGN_K);
    end

endmodule

// File: rtl/sata_rx_dword_aligner.sv
// Finds the byte lane carrying ALIGN's K28.5, confirms it over repeated
// ALIGNs, and re-frames the receive stream so byte 0 is always dword-aligned.
module sata_rx_dword_aligner
    import sata_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rx_data,
    input  logic [3:0]  rx_datak,
    input  logic [3:0]  rx_syncstatus,
    output logic [31:0] o_data,
    output logic [3:0]  o_datak,
    output logic        o_align,
    output logic        o_locked,
    output logic [1:0]  o_shift
);

    localparam logic [3:0] LOCK_N = LOCK_CNT[3:0];
    localparam logic [3:0] LOSS_N = LOSS_CNT[3:0];

    logic [31:0]            prev_data_q;
    logic [3:0]             prev_datak_q;
    logic [8*WIN_BYTES-1:0] win_data_s;
    logic [WIN_BYTES-1:0]   win_datak_s;
    logic [3:0]             match_s;
    logic                   hit_s;
    logic [1:0]             hk_s;
    logic                   sync_ok_s;

    aligner_state_t state_q, state_d;
    logic [1:0]     shift_q, shift_d;
    logic [1:0]     cand_q, cand_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     miss_q, miss_d;

    logic [31:0] o_data_q, o_data_d;
    logic [3:0]  o_datak_q, o_datak_d;
    logic        o_align_q, o_align_d;
    logic        o_locked_q, o_locked_d;
    logic [1:0]  o_shift_q, o_shift_d;

    // Byte 3 of the current word can only complete a candidate one cycle later,
    // so the window stops at current byte 2.
    assign win_data_s  = {rx_data[23:0], prev_data_q};
    assign win_datak_s = {rx_datak[2:0], prev_datak_q};
    assign sync_ok_s   = &rx_syncstatus;
    assign hit_s       = |match_s;
    assign hk_s        = lowest_lane(match_s);

    sata_dword_lane_matcher u_matcher (
        .win_data_i  (win_data_s),
        .win_datak_i (win_datak_s),
        .match_o     (match_s)
    );

    // Previous-word window register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_data_q  <= 32'h0000_0000;
            prev_datak_q <= 4'b0000;
        end else begin
            prev_data_q  <= rx_data;
            prev_datak_q <= rx_datak;
        end
    end

    // Hunt / verify / locked next-state and counter logic.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        miss_d  = miss_q;
        case (state_q)
            HUNT: begin
                if (hit_s && sync_ok_s) begin
                    cand_d = hk_s;
                    cnt_d  = 4'd1;
                    if (LOCK_N == 4'd1) begin
                        state_d = LOCKED;
                        shift_d = hk_s;
                        miss_d  = 4'd0;
                    end else begin
                        state_d = VERIFY;
                    end
                end else begin
                    state_d = HUNT;
                end
            end
            VERIFY: begin
                if (!sync_ok_s) begin
                    state_d = HUNT;
                end else if (match_s[cand_q]) begin
                    cnt_d = cnt_q + 4'd1;
                    if ((cnt_q + 4'd1) == LOCK_N) begin
                        state_d = LOCKED;
                        shift_d = cand_q;
                        miss_d  = 4'd0;
                    end else begin
                        state_d = VERIFY;
                    end
                end else if (hit_s) begin
                    cand_d = hk_s;
                    cnt_d  = 4'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            LOCKED: begin
                if (!sync_ok_s) begin
                    state_d = HUNT;
                    miss_d  = 4'd0;
                end else if (match_s[shift_q]) begin
                    miss_d = 4'd0;
                end else if (hit_s) begin
                    miss_d = miss_q + 4'd1;
                    if ((miss_q + 4'd1) == LOSS_N) begin
                        state_d = HUNT;
                        miss_d  = 4'd0;
                    end else begin
                        state_d = LOCKED;
                    end
                end else begin
                    miss_d = miss_q;
                end
            end
            default: begin
                state_d = HUNT;
                miss_d  = 4'd0;
            end
        endcase
    end

    // FSM and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HUNT;
            shift_q <= 2'd0;
            cand_q  <= 2'd0;
            cnt_q   <= 4'd0;
            miss_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            miss_q  <= miss_d;
        end
    end

    // Output mux uses the next-state shift so the locking ALIGN leaves aligned.
    always_comb begin
        o_data_d   = win_data_s[{1'b0, shift_d, 3'b000} +: 32];
        o_datak_d  = win_datak_s[{1'b0, shift_d} +: 4];
        o_align_d  = match_s[shift_d];
        o_locked_d = (state_d == LOCKED);
        o_shift_d  = shift_d;
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_data_q   <= 32'h0000_0000;
            o_datak_q  <= 4'b0000;
            o_align_q  <= 1'b0;
            o_locked_q <= 1'b0;
            o_shift_q  <= 2'd0;
        end else begin
            o_data_q   <= o_data_d;
            o_datak_q  <= o_datak_d;
            o_align_q  <= o_align_d;
            o_locked_q <= o_locked_d;
            o_shift_q  <= o_shift_d;
        end
    end

    assign o_data   = o_data_q;
    assign o_datak  = o_datak_q;
    assign o_align  = o_align_q;
    assign o_locked = o_locked_q;
    assign o_shift  = o_shift_q;

endmodule

// File: tb/tb_sata_rx_dword_aligner.sv
// Bench for sata_rx_dword_aligner: byte-stream stimulus, byte-level reference
// model of ALIGN detection and lock rules, per-scenario tasks.
module tb_sata_rx_dword_aligner;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rx_data;
    logic [3:0]  rx_datak;
    logic [3:0]  rx_syncstatus;
    logic [31:0] o_data;
    logic [3:0]  o_datak;
    logic        o_align;
    logic        o_locked;
    logic [1:0]  o_shift;

    sata_rx_dword_aligner #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_datak      (rx_datak),
        .rx_syncstatus (rx_syncstatus),
        .o_data        (o_data),
        .o_datak       (o_datak),
        .o_align       (o_align),
        .o_locked      (o_locked),
        .o_shift       (o_shift)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [7:0] tx_b[$];
    logic       tx_k[$];
    logic [7:0] hb[$];
    logic       hkf[$];
    int         words;
    int         m_st, m_cand, m_cnt, m_miss, m_shift;
    logic [3:0] m_match;
    logic [39:0] exp_v;
    wire  [39:0] got_v = {o_data, o_datak, o_align, o_locked, o_shift};

    task automatic push_byte(input logic [7:0] b, input logic k);
        tx_b.push_back(b);
        tx_k.push_back(k);
    endtask

    task automatic push_align();
        push_byte(8'hBC, 1'b1);
        push_byte(8'h4A, 1'b0);
        push_byte(8'h4A, 1'b0);
        push_byte(8'h7B, 1'b0);
    endtask

    task automatic push_rand(input int nbytes);
        for (int i = 0; i < nbytes; i++) push_byte(8'($urandom), 1'b0);
    endtask

    task automatic model_reset();
        hb.delete();
        hkf.delete();
        tx_b.delete();
        tx_k.delete();
        for (int i = 0; i < 4; i++) begin
            hb.push_back(8'h00);
            hkf.push_back(1'b0);
        end
        words = 0;
        m_st = 0; m_cand = 0; m_cnt = 0; m_miss = 0; m_shift = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        rx_data = 32'h0; rx_datak = 4'h0; rx_syncstatus = 4'hF;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Lock rules on ALIGN sightings (0 hunt, 1 verify, 2 locked).
    task automatic model_rules(input logic [3:0] mv, input bit sok);
        int low;
        low = mv[0] ? 0 : mv[1] ? 1 : mv[2] ? 2 : 3;
        if (m_st == 0) begin
            if (mv != 4'b0 && sok) begin
                m_cand = low; m_cnt = 1;
                if (LOCK_CNT == 1) begin m_st = 2; m_shift = low; m_miss = 0; end
                else m_st = 1;
            end
        end else if (m_st == 1) begin
            if (!sok) m_st = 0;
            else if (mv[m_cand]) begin
                m_cnt++;
                if (m_cnt == LOCK_CNT) begin m_st = 2; m_shift = m_cand; m_miss = 0; end
            end else if (mv != 4'b0) begin
                m_cand = low; m_cnt = 1;
            end
        end else begin
            if (!sok) begin m_st = 0; m_miss = 0; end
            else if (mv[m_shift]) m_miss = 0;
            else if (mv != 4'b0) begin
                m_miss++;
                if (m_miss == LOSS_CNT) begin m_st = 0; m_miss = 0; end
            end
        end
    endtask

    // Drive one word from the byte queue, clock it, and update the model.
    task automatic step(input logic [3:0] sync);
        int b;
        if (tx_b.size() < 4) push_rand(4 - tx_b.size());
        for (int i = 0; i < 4; i++) begin
            rx_data[8*i +: 8] = tx_b.pop_front();
            rx_datak[i]       = tx_k.pop_front();
            hb.push_back(rx_data[8*i +: 8]);
            hkf.push_back(rx_datak[i]);
        end
        rx_syncstatus = sync;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            b = 4 * words + k;
            m_match[k] = (hb[b] == 8'hBC) && (hb[b+1] == 8'h4A) && (hb[b+2] == 8'h4A) &&
                         (hb[b+3] == 8'h7B) && hkf[b] && !hkf[b+1] && !hkf[b+2] && !hkf[b+3];
        end
        model_rules(m_match, sync == 4'hF);
        b = 4 * words + m_shift;
        exp_v = {hb[b+3], hb[b+2], hb[b+1], hb[b], hkf[b+3], hkf[b+2], hkf[b+1], hkf[b],
                 m_match[m_shift], (m_st == 2), 2'(m_shift)};
        words++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_data = 32'h7B4A4ABC; rx_datak = 4'b0001; rx_syncstatus = 4'hF;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (got_v !== 40'h0) $display("FAIL reset_state got=%h want=%h", got_v, 40'h0);
        else passed++;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_lock(input int off);
        int lock_at;
        apply_reset();
        if (off == 1) push_byte(8'h7B, 1'b0);
        repeat (9) push_align();
        lock_at = 0;
        for (int c = 1; c <= 8; c++) begin
            step(4'hF);
            checks++;
            if (got_v !== exp_v) $display("FAIL lock%0d_cycle%0d got=%h want=%h", off, c, got_v, exp_v);
            else passed++;
            if (o_locked === 1'b1 && lock_at == 0) begin
                lock_at = c;
                checks++;
                if (o_align !== 1'b1 || o_shift !== 2'(off) || o_data !== 32'h7B4A4ABC || o_datak !== 4'b0001)
                    $display("FAIL lock%0d_first align=%b shift=%0d data=%h k=%b want 1/%0d/7b4a4abc/0001",
                             off, o_align, o_shift, o_data, o_datak, off);
                else passed++;
            end
        end
        checks++;
        if (lock_at != 5) $display("FAIL lock%0d_cycle got=%0d want=5", off, lock_at);
        else passed++;
    endtask

    task automatic test_verify_change();
        int lock_at;
        apply_reset();
        push_rand(2);
        repeat (2) push_align();
        push_rand(1);
        repeat (6) push_align();
        push_rand(1);
        lock_at = 0;
        for (int c = 1; c <= 9; c++) begin
            step(4'hF);
            checks++;
            if (got_v !== exp_v) $display("FAIL verify_change_cycle%0d got=%h want=%h", c, got_v, exp_v);
            else passed++;
            if (o_locked === 1'b1 && lock_at == 0) lock_at = c;
        end
        checks++;
        if (lock_at != 7 || o_shift !== 2'd3)
            $display("FAIL verify_change_lock cycle=%0d shift=%0d want 7/3", lock_at, o_shift);
        else passed++;
    endtask

    task automatic test_loss();
        int run;
        bit seen8;
        apply_reset();
        repeat (6) push_align();
        push_rand(2);
        repeat (7) begin push_align(); push_rand(4 * $urandom_range(0, 2)); end
        push_rand(2);
        push_align();
        push_rand(4);
        push_rand(2);
        repeat (8) begin push_align(); push_rand(4 * $urandom_range(0, 2)); end
        push_rand(2);
        run = 0; seen8 = 0;
        while (tx_b.size() > 0) begin
            step(4'hF);
            checks++;
            if (got_v !== exp_v) $display("FAIL loss_cycle%0d got=%h want=%h", words, got_v, exp_v);
            else passed++;
            if (m_match[0]) run = 0;
            else if (m_match[2]) run++;
            if (m_match[0] && words > 6) begin
                checks++;
                if (o_locked !== 1'b1) $display("FAIL loss_reanchor locked=%b want=1", o_locked);
                else passed++;
            end
            if (m_match[2] && run == 7) begin
                checks++;
                if (o_locked !== 1'b1) $display("FAIL loss_7th locked=%b want=1", o_locked);
                else passed++;
            end
            if (m_match[2] && run == 8) begin
                seen8 = 1;
                checks++;
                if (o_locked !== 1'b0) $display("FAIL loss_8th locked=%b want=0", o_locked);
                else passed++;
            end
        end
        checks++;
        if (!seen8) $display("FAIL loss_run_seen got=0 want=1");
        else passed++;
    endtask

    task automatic test_sync_drop();
        int seen, relock;
        apply_reset();
        repeat (6) push_align();
        repeat (6) step(4'hF);
        repeat (9) push_align();
        step(4'hF & ~(4'b0001 << $urandom_range(0, 3)));
        checks++;
        if (o_locked !== 1'b0 || got_v !== exp_v)
            $display("FAIL sync_drop locked=%b got=%h want=%h", o_locked, got_v, exp_v);
        else passed++;
        seen = 0; relock = 0;
        for (int c = 0; c < 7; c++) begin
            step(4'hF);
            if (m_match != 4'b0) seen++;
            checks++;
            if (got_v !== exp_v) $display("FAIL sync_relock_cycle%0d got=%h want=%h", c, got_v, exp_v);
            else passed++;
            if (o_locked === 1'b1 && relock == 0) relock = seen;
        end
        checks++;
        if (relock != 4) $display("FAIL sync_relock_aligns got=%0d want=4", relock);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int lock_at;
        apply_reset();
        repeat (7) push_align();
        repeat (6) step(4'hF);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (got_v !== 40'h0) $display("FAIL reset_mid_async got=%h want=%h", got_v, 40'h0);
        else passed++;
        #1 reset = 1'b0;
        model_reset();
        repeat (7) push_align();
        lock_at = 0;
        for (int c = 1; c <= 6; c++) begin
            step(4'hF);
            checks++;
            if (got_v !== exp_v) $display("FAIL reset_mid_cycle%0d got=%h want=%h", c, got_v, exp_v);
            else passed++;
            if (o_locked === 1'b1 && lock_at == 0) lock_at = c;
        end
        checks++;
        if (lock_at != 5) $display("FAIL reset_mid_relock got=%0d want=5", lock_at);
        else passed++;
    endtask

    task automatic test_random();
        int r;
        logic [3:0] sync;
        apply_reset();
        for (int i = 0; i < 160; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60) push_align();
            else if (r < 85) push_rand(4);
            else push_rand($urandom_range(1, 3));
        end
        while (tx_b.size() > 0) begin
            sync = ($urandom_range(0, 99) < 3) ? 4'(~(4'b0001 << $urandom_range(0, 3))) : 4'hF;
            step(sync);
            checks++;
            if (got_v !== exp_v) $display("FAIL random_cycle%0d got=%h want=%h", words, got_v, exp_v);
            else passed++;
        end
    endtask

    initial begin
        reset = 1'b1;
        rx_data = 32'h0; rx_datak = 4'h0; rx_syncstatus = 4'hF;
        test_reset();
        test_lock(0);
        test_lock(1);
        test_verify_change();
        test_loss();
        test_sync_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
